// File: rtl/div_unit_pkg.sv
// Shared definitions for the signed iterative divider: FSM encoding,
// default operand width and iteration-counter sizing.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // The iteration counter has one spare bit above the index range.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // The remainder is always below the divisor, so the shifted trial value
    // fits in WIDTH+1 bits and the borrow bit tells whether it fits.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Signed divider (MIPS DIV semantics): WIDTH cycles of unsigned restoring
// division on operand magnitudes, a sign-fix cycle, then a result cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] div_high_out,
    output logic [WIDTH-1:0] div_low_out
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;
    logic             zero_dvs;

    assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign zero_dvs = (divisor == '0);

    // busy stays high through the done cycle, so it also blocks a start
    // arriving while the result is being presented.
    assign accept = (state == S_IDLE) && start && !busy;

    // quo_q starts as the dividend magnitude; its MSB feeds each step and
    // quotient bits shift in at the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = zero_dvs ? S_DONE : S_CALC;
            S_CALC: if (cnt == CNT_W'(WIDTH-1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, status flags and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
            div_high_out <= '0;
            div_low_out  <= '0;
            cnt          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        busy     <= 1'b1;
                        div_zero <= zero_dvs;
                        done     <= zero_dvs;
                        cnt      <= '0;
                        rem_q    <= '0;
                        quo_q    <= dvd_mag;
                        dvs_q    <= dvs_mag;
                        neg_quo  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem  <= dividend[WIDTH-1];
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_q};
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (neg_quo) quo_q <= -quo_q;
                    if (neg_rem) rem_q <= -rem_q;
                end
                S_DONE: begin
                    // A divide-by-zero already pulsed done on acceptance;
                    // it just releases busy and leaves the results alone.
                    if (div_zero) begin
                        busy <= 1'b0;
                    end else begin
                        done         <= 1'b1;
                        div_high_out <= rem_q;
                        div_low_out  <= quo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-level behavioural scoreboard
// compared every cycle, directed literal cases, and randomized traffic.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] div_high_out;
    logic [W-1:0] div_low_out;

    int compared   = 0;
    int mismatched = 0;
    int fail_lines = 0;
    bit chk_en     = 1'b0;

    div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero),
        .div_high_out (div_high_out),
        .div_low_out  (div_low_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: timing expressed as edge counts from acceptance,
    // results from plain 64-bit signed arithmetic (truncating division).
    longint       ecnt = 0;
    bit           m_busy = 0, m_done = 0, m_zero = 0, pend = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    longint       done_at = 0, busy_end = 0;

    always @(posedge clk) begin
        bit     b0;
        longint sa, sb, q, r;
        ecnt++;
        b0 = m_busy;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_zero = 0; pend = 0;
            m_hi = '0; m_lo = '0;
        end else begin
            m_done = 0;
            if (pend && ecnt == done_at) begin
                m_done = 1; m_hi = p_hi; m_lo = p_lo; pend = 0;
            end
            if (m_busy && ecnt == busy_end) m_busy = 0;
            if (!b0 && start) begin
                m_busy = 1;
                m_zero = (divisor == 0);
                if (m_zero) begin
                    m_done   = 1;
                    busy_end = ecnt + 1;
                end else begin
                    sa = longint'($signed(dividend));
                    sb = longint'($signed(divisor));
                    q  = sa / sb;
                    r  = sa % sb;
                    p_lo = q[W-1:0];
                    p_hi = r[W-1:0];
                    pend     = 1;
                    done_at  = ecnt + W + 2;
                    busy_end = ecnt + W + 3;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            compared++;
            if (busy !== m_busy || done !== m_done || div_zero !== m_zero ||
                div_high_out !== m_hi || div_low_out !== m_lo) begin
                mismatched++;
                if (fail_lines < 20) begin
                    fail_lines++;
                    $display("FAIL cycle_model t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h want busy=%b done=%b dz=%b hi=%h lo=%h",
                             $time, busy, done, div_zero, div_high_out, div_low_out,
                             m_busy, m_done, m_zero, m_hi, m_lo);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge: present start for one cycle, then scramble the
    // operand inputs to show they were latched.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    // lat = edges from acceptance to the edge after which done is seen.
    // inj >= 0 pulses start with 9/3 at that point while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, output int lat);
        issue(a, b);
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == inj) begin start = 1'b1; dividend = 9; divisor = 3; end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (lat >= 100) check("done_timeout", 32'(lat), 32'(W + 2));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("idle_timeout", 32'(n), 0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom % 6)
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($signed($urandom_range(0, 40)) - 20);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dz",   32'(div_zero), 0);
        check("rst_hi",   div_high_out, 0);
        check("rst_lo",   div_low_out, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(100, 7, -1, lat);
        check("100/7 lat", 32'(lat), 34);
        check("100/7 lo", div_low_out, 14);
        check("100/7 hi", div_high_out, 2);
        check("100/7 dz", 32'(div_zero), 0);
        wait_idle();

        run_op(5, 0, -1, lat);
        check("5/0 lat", 32'(lat), 0);
        check("5/0 dz", 32'(div_zero), 1);
        check("5/0 lo", div_low_out, 14);
        check("5/0 hi", div_high_out, 2);
        wait_idle();

        run_op(-32'sd7, 2, -1, lat);
        check("-7/2 lo", div_low_out, 32'hFFFF_FFFD);
        check("-7/2 hi", div_high_out, 32'hFFFF_FFFF);
        check("-7/2 dz", 32'(div_zero), 0);
        wait_idle();

        run_op(7, -32'sd2, -1, lat);
        check("7/-2 lo", div_low_out, 32'hFFFF_FFFD);
        check("7/-2 hi", div_high_out, 1);
        wait_idle();

        run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
        check("min/-1 lo", div_low_out, 32'h8000_0000);
        check("min/-1 hi", div_high_out, 0);
        check("min/-1 dz", 32'(div_zero), 0);
        wait_idle();

        // Start while busy is dropped.
        run_op(100, 7, 10, lat);
        check("busy_start lat", 32'(lat), 34);
        check("busy_start lo", div_low_out, 14);
        check("busy_start hi", div_high_out, 2);

        // Start in the done cycle is dropped; held one more cycle it is taken.
        start = 1'b1; dividend = 8; divisor = 2;
        @(negedge clk);
        check("done_cycle busy", 32'(busy), 0);
        run_op(8, 2, -1, lat);
        check("after_done lat", 32'(lat), 34);
        check("after_done lo", div_low_out, 4);
        check("after_done hi", div_high_out, 0);
        wait_idle();

        // Reset mid-calculation aborts; start right at release is accepted.
        issue(100, 7);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst busy", 32'(busy), 0);
        check("mid_rst done", 32'(done), 0);
        check("mid_rst hi", div_high_out, 0);
        check("mid_rst lo", div_low_out, 0);
        reset_n = 1'b1;
        run_op(9, 3, -1, lat);
        check("post_rst lat", 32'(lat), 34);
        check("post_rst lo", div_low_out, 3);
        check("post_rst hi", div_high_out, 0);
        wait_idle();

        // Randomized traffic, checked by the every-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom % 6) == 0;
            dividend = rnd_val();
            divisor  = rnd_val();
            reset_n  = ($urandom % 700) != 0;
            @(negedge clk);
        end
        reset_n = 1'b1; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
